vib_pole_tracker: RTL and testbench

Parametrised per-channel peak tracker for the vibration-detect path. It sits after the per-channel sample front end, which delivers a magnitude, a sign bit and a strobe for each channel. For every full positive half-cycle it reports the largest positive magnitude and the lobe length in samples. It does the same for every full negative half-cycle, and it rejects short noise lobes.

---
 rtl/vib_pole_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_vib_pole_tracker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vib_pole_tracker.sv
// vib_pole_tracker: per-channel half-cycle peak tracker.
// Each channel syncs its sample strobe, follows the sign of the incoming
// magnitude and reports the peak and length of every complete lobe.
// Lobes shorter than MIN_LEN samples are dropped.
// Optional build macro SEARCH_POLE_PP_EN adds peak-to-peak reporting
// (positive peak plus the following negative peak). Without it, pp/pp_en
// are tied to 0.
module vib_pole_tracker #(
  parameter int CH      = 4,
  parameter int DW      = 16,
  parameter int CW      = 12,
  parameter int MIN_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 detect_enable,
  input  logic [CH-1:0]        dat_en,
  input  logic [CH*DW-1:0]     dat,
  input  logic [CH-1:0]        dat_sign,
  output logic [CH*DW-1:0]     pos_peak,
  output logic [CH*CW-1:0]     pos_len,
  output logic [CH-1:0]        pos_peak_en,
  output logic [CH*DW-1:0]     neg_peak,
  output logic [CH*CW-1:0]     neg_len,
  output logic [CH-1:0]        neg_peak_en,
  output logic [CH*(DW+1)-1:0] pp,
  output logic [CH-1:0]        pp_en
);

  typedef enum logic [1:0] {IDLE, SYNC, POS, NEG} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] MIN_L   = CW'(MIN_LEN);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [2:0]    sync_q;          // bit0 = s0, bit1 = s1, bit2 = s2
    logic          ev;
    logic [DW-1:0] smp;
    logic          sgn;
    state_t        state_q, state_d;
    logic          ref_q, ref_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pos_close, neg_close, close_ok;
    logic [DW-1:0] pk_pos_q, pk_pos_d, pk_neg_q, pk_neg_d;
    logic [CW-1:0] ln_pos_q, ln_pos_d, ln_neg_q, ln_neg_d;
    logic          pos_en_q, pos_en_d, neg_en_q, neg_en_d;

    assign smp       = dat[g*DW +: DW];
    assign sgn       = dat_sign[g];
    assign ev        = sync_q[1] & ~sync_q[2];
    assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
    assign close_ok  = (cnt_q >= MIN_L);
    assign pos_close = detect_enable && ev && (state_q == POS) && sgn;
    assign neg_close = detect_enable && ev && (state_q == NEG) && !sgn;

    // Strobe synchroniser: the event is the rising edge seen at s1.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[1:0], dat_en[g]};
    end

    // Next-state and lobe bookkeeping.
    always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d  = state_q;
      ref_d    = ref_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      pk_pos_d = pk_pos_q;
      ln_pos_d = ln_pos_q;
      pk_neg_d = pk_neg_q;
      ln_neg_d = ln_neg_q;
      pos_en_d = 1'b0;
      neg_en_d = 1'b0;
      if (!detect_enable) begin
        // Abort: any open lobe is discarded, outputs keep their last values.
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else if (ev) begin
        unique case (state_q)
          IDLE: begin
            ref_d   = sgn;
            state_d = SYNC;
          end
          SYNC: begin
            // Wait for the first sign change so the partial lobe is skipped.
            if (sgn != ref_q) begin
              acc_d   = smp;
              cnt_d   = CW'(1);
              state_d = sgn ? NEG : POS;
            end
          end
          POS: begin
            if (pos_close) begin
              if (close_ok) begin
                pk_pos_d = acc_q;
                ln_pos_d = cnt_q;
                pos_en_d = 1'b1;
              end
              acc_d   = smp;
              cnt_d   = CW'(1);
              state_d = NEG;
            end else begin
              if (smp >= acc_q) acc_d = smp;
              cnt_d = cnt_inc;
            end
          end
          NEG: begin
            if (neg_close) begin
              if (close_ok) begin
                pk_neg_d = acc_q;
                ln_neg_d = cnt_q;
                neg_en_d = 1'b1;
              end
              acc_d   = smp;
              cnt_d   = CW'(1);
              state_d = POS;
            end else begin
              if (smp >= acc_q) acc_d = smp;
              cnt_d = cnt_inc;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= IDLE;
        ref_q    <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
        pk_pos_q <= '0;
        ln_pos_q <= '0;
        pk_neg_q <= '0;
        ln_neg_q <= '0;
        pos_en_q <= 1'b0;
        neg_en_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        ref_q    <= ref_d;
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
        pk_pos_q <= pk_pos_d;
        ln_pos_q <= ln_pos_d;
        pk_neg_q <= pk_neg_d;
        ln_neg_q <= ln_neg_d;
        pos_en_q <= pos_en_d;
        neg_en_q <= neg_en_d;
      end
    end

    assign pos_peak[g*DW +: DW] = pk_pos_q;
    assign pos_len[g*CW +: CW]  = ln_pos_q;
    assign pos_peak_en[g]       = pos_en_q;
    assign neg_peak[g*DW +: DW] = pk_neg_q;
    assign neg_len[g*CW +: CW]  = ln_neg_q;
    assign neg_peak_en[g]       = neg_en_q;

`ifdef SEARCH_POLE_PP_EN
    logic          pv_q, pv_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW:0]   pp_q, pp_d;
    logic          pp_en_q, pp_en_d;

    // Pair a reported positive lobe with the next reported negative lobe.
    always_comb begin
      pv_d    = pv_q;
      hold_d  = hold_q;
      pp_d    = pp_q;
      pp_en_d = 1'b0;
      if (!detect_enable) begin
        pv_d = 1'b0;
      end else if (pos_close) begin
        pv_d = close_ok;
        if (close_ok) hold_d = acc_q;
      end else if (neg_close) begin
        if (close_ok && pv_q) begin
          pp_d    = {1'b0, hold_q} + {1'b0, acc_q};
          pp_en_d = 1'b1;
        end
        pv_d = 1'b0;
      end
    end

    // Peak-to-peak registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        pv_q    <= 1'b0;
        hold_q  <= '0;
        pp_q    <= '0;
        pp_en_q <= 1'b0;
      end else begin
        pv_q    <= pv_d;
        hold_q  <= hold_d;
        pp_q    <= pp_d;
        pp_en_q <= pp_en_d;
      end
    end

    assign pp[g*(DW+1) +: DW+1] = pp_q;
    assign pp_en[g]             = pp_en_q;
`else
    assign pp[g*(DW+1) +: DW+1] = '0;
    assign pp_en[g]             = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vib_pole_tracker.sv
// tb_vib_pole_tracker: directed-vector bench with a per-channel scoreboard.
// Stimulus pushes the expected lobe reports; a negedge monitor pops and
// compares whenever a pulse appears, and flags any output change without
// its pulse. Expected pp values follow SEARCH_POLE_PP_EN.
module tb_vib_pole_tracker;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CW = 12;
  localparam int MIN_LEN = 3;
`ifdef SEARCH_POLE_PP_EN
  localparam bit PP_ON = 1'b1;
`else
  localparam bit PP_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 detect_enable;
  logic [CH-1:0]        dat_en;
  logic [CH*DW-1:0]     dat;
  logic [CH-1:0]        dat_sign;
  logic [CH*DW-1:0]     pos_peak, neg_peak;
  logic [CH*CW-1:0]     pos_len, neg_len;
  logic [CH-1:0]        pos_peak_en, neg_peak_en, pp_en;
  logic [CH*(DW+1)-1:0] pp;

  vib_pole_tracker #(.CH(CH), .DW(DW), .CW(CW), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .detect_enable(detect_enable),
    .dat_en(dat_en), .dat(dat), .dat_sign(dat_sign),
    .pos_peak(pos_peak), .pos_len(pos_len), .pos_peak_en(pos_peak_en),
    .neg_peak(neg_peak), .neg_len(neg_len), .neg_peak_en(neg_peak_en),
    .pp(pp), .pp_en(pp_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit neg;
    int peak;
    int len;
    bit ppen;
    int ppv;
    int due;
  } rec_t;

  rec_t sb [CH][$];
  rec_t mon_r;
  int   chg;

  logic [CH*DW-1:0]     prev_pos_peak, prev_neg_peak;
  logic [CH*CW-1:0]     prev_pos_len, prev_neg_len;
  logic [CH*(DW+1)-1:0] prev_pp;

  // Independence vectors: 8 simultaneous samples on all channels.
  int sg [CH][8] = '{'{1,0,0,0,1,1,1,0}, '{0,1,0,0,0,1,1,1},
                     '{0,0,1,1,1,1,0,1}, '{1,1,1,1,1,1,1,1}};
  int mg [CH][8] = '{'{5,10,30,20,7,40,9,1}, '{9,3,100,200,150,6,7,8},
                     '{1,2,50,80,80,60,3,4}, '{7,7,7,7,7,7,7,7}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected report for the strobe just issued (pulse in the current cycle).
  task automatic exp_rec(input int ch, input bit neg, input int peak, input int len,
                         input bit ppen, input int ppv);
    rec_t r;
    r.neg  = neg;
    r.peak = peak;
    r.len  = len;
    r.ppen = ppen;
    r.ppv  = ppv;
    r.due  = cyc;
    sb[ch].push_back(r);
  endtask

  // Called just after a rising edge; returns just after edge 2 of the strobe.
  task automatic issue(input logic [CH-1:0] m, input logic [CH*DW-1:0] d, input logic [CH-1:0] s);
    dat      = d;
    dat_sign = s;
    dat_en   = m;
    @(posedge clk);
    #1 dat_en = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic one(input int ch, input int mag, input bit sgn);
    logic [CH*DW-1:0] d;
    logic [CH-1:0]    m;
    logic [CH-1:0]    s;
    d = '0;
    m = '0;
    s = '0;
    d[ch*DW +: DW] = DW'(mag);
    m[ch] = 1'b1;
    s[ch] = sgn;
    issue(m, d, s);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos_peak"}, pos_peak, 0);
    check({tag, "_pos_len"}, pos_len, 0);
    check({tag, "_pos_en"}, pos_peak_en, 0);
    check({tag, "_neg_peak"}, neg_peak, 0);
    check({tag, "_neg_len"}, neg_len, 0);
    check({tag, "_neg_en"}, neg_peak_en, 0);
    check({tag, "_pp"}, pp, 0);
    check({tag, "_pp_en"}, pp_en, 0);
  endtask

  // Monitor: pop and compare on every pulse, and catch unannounced changes.
  always @(negedge clk) begin
    chg = 0;
    if (rst === 1'b0) begin
      for (int i = 0; i < CH; i++) begin
        if (pos_peak_en[i] || neg_peak_en[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("ch%0d_unexpected_pulse", i), {pos_peak_en[i], neg_peak_en[i]}, 0);
          end else begin
            mon_r = sb[i].pop_front();
            check($sformatf("ch%0d_kind_neg", i), neg_peak_en[i], mon_r.neg);
            check($sformatf("ch%0d_pulse_cycle", i), cyc, mon_r.due);
            check($sformatf("ch%0d_peak", i),
                  mon_r.neg ? neg_peak[i*DW +: DW] : pos_peak[i*DW +: DW], mon_r.peak);
            check($sformatf("ch%0d_len", i),
                  mon_r.neg ? neg_len[i*CW +: CW] : pos_len[i*CW +: CW], mon_r.len);
            check($sformatf("ch%0d_pp_en", i), pp_en[i], mon_r.ppen);
            if (mon_r.ppen) check($sformatf("ch%0d_pp", i), pp[i*(DW+1) +: DW+1], mon_r.ppv);
          end
        end else if (pp_en[i]) begin
          check($sformatf("ch%0d_stray_pp_en", i), pp_en[i], 0);
        end
        if (!pos_peak_en[i] && (pos_peak[i*DW +: DW] != prev_pos_peak[i*DW +: DW] ||
                                pos_len[i*CW +: CW] != prev_pos_len[i*CW +: CW])) chg++;
        if (!neg_peak_en[i] && (neg_peak[i*DW +: DW] != prev_neg_peak[i*DW +: DW] ||
                                neg_len[i*CW +: CW] != prev_neg_len[i*CW +: CW])) chg++;
        if (!pp_en[i] && pp[i*(DW+1) +: DW+1] != prev_pp[i*(DW+1) +: DW+1]) chg++;
      end
      check("output_hold", chg, 0);
    end
    prev_pos_peak = pos_peak;
    prev_pos_len  = pos_len;
    prev_neg_peak = neg_peak;
    prev_neg_len  = neg_len;
    prev_pp       = pp;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*DW-1:0] d;
    logic [CH-1:0]    s;
    int s0[8] = '{1,0,0,0,1,1,1,0};
    int m0[8] = '{5,10,30,20,7,40,9,1};
    int s1[7] = '{1,0,0,1,1,1,0};
    int m1[7] = '{1,50,60,2,3,4,1};
    int s2[5] = '{0,1,1,1,0};
    int m2[5] = '{3,8,9,2,5};

    rst = 1'b1;
    detect_enable = 1'b0;
    dat_en = '0;
    dat = '0;
    dat_sign = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    rst = 1'b0;
    detect_enable = 1'b1;
    @(posedge clk);
    #1;

    // Ch0 basic positive then negative lobe.
    for (int k = 0; k < 8; k++) begin
      one(0, m0[k], s0[k][0]);
      if (k == 4) exp_rec(0, 1'b0, 30, 3, 1'b0, 0);
      if (k == 7) exp_rec(0, 1'b1, 40, 3, PP_ON, 70);
    end

    // Ch1 short positive lobe dropped; negative lobe of exactly MIN_LEN kept.
    for (int k = 0; k < 7; k++) begin
      one(1, m1[k], s1[k][0]);
      if (k == 6) exp_rec(1, 1'b1, 4, 3, 1'b0, 0);
    end

    // Reset held 3 cycles in the middle of an open ch0 lobe.
    one(0, 33, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst = 1'b0;

    // After reset ch0 starts again from IDLE.
    for (int k = 0; k < 5; k++) begin
      one(0, m2[k], s2[k][0]);
      if (k == 4) exp_rec(0, 1'b1, 9, 3, 1'b0, 0);
    end

    // Enable abort in the middle of a ch2 positive lobe.
    one(2, 7, 1'b1);
    one(2, 15, 1'b0);
    one(2, 16, 1'b0);
    one(2, 90, 1'b0);
    detect_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 detect_enable = 1'b1;
    one(2, 11, 1'b0);
    one(2, 12, 1'b0);
    one(2, 20, 1'b1);
    one(2, 25, 1'b1);
    one(2, 21, 1'b1);
    one(2, 4, 1'b0);
    exp_rec(2, 1'b1, 25, 3, 1'b0, 0);

    // All channels back to IDLE, then simultaneous strobes.
    detect_enable = 1'b0;
    @(posedge clk);
    #1 detect_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < CH; c++) begin
        d[c*DW +: DW] = DW'(mg[c][k]);
        s[c] = sg[c][k][0];
      end
      issue('1, d, s);
      if (k == 4) exp_rec(0, 1'b0, 30, 3, 1'b0, 0);
      if (k == 5) exp_rec(1, 1'b0, 200, 3, 1'b0, 0);
      if (k == 6) exp_rec(2, 1'b1, 80, 4, 1'b0, 0);
      if (k == 7) exp_rec(0, 1'b1, 40, 3, PP_ON, 70);
    end

    // Ch3 long positive lobe: length saturates at 2^CW-1.
    one(3, 5, 1'b0);
    for (int i = 0; i < 5000; i++) one(3, (i == 4500) ? 999 : 100 + (i % 50), 1'b0);
    one(3, 2, 1'b1);
    exp_rec(3, 1'b0, 999, 4095, 1'b0, 0);
    one(3, 3, 1'b1);
    one(3, 1, 1'b1);
    one(3, 6, 1'b0);
    exp_rec(3, 1'b1, 3, 3, PP_ON, 1002);

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) check($sformatf("ch%0d_missing_reports", i), sb[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
